// File: rtl/memc_sequencer_if.sv
// Data-memory port between the MEMC copy sequencer (master) and the memory arbiter (slave).
// Read data returns one cycle after a granted read.
interface memc_sequencer_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_we;
    logic             mem_gnt;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_gnt,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_gnt,
        output mem_rdata
    );
endinterface

// File: rtl/memc_sequencer.sv
// Multi-cycle MEMC word copier: reads a word from src, writes it to dst, repeats count times,
// stalling the pipeline front end while the copy runs.
module memc_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     src_addr,
    input  logic [WIDTH-1:0]     dst_addr,
    input  logic [CNT_W-1:0]     count,
    memc_sequencer_if.master     bus,
    output logic                 stall,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {StIdle, StRd, StWt, StWr, StFin} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] src_q;
    logic [WIDTH-1:0] dst_q;
    logic [CNT_W-1:0] rem_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        rem_q   <= count;
                        state_q <= (count != '0) ? StRd : StFin;
                    end
                end
                StRd: begin
                    if (bus.mem_gnt) state_q <= StWt;
                end
                // The read was issued in RD, so capture regardless of the current grant.
                StWt: begin
                    data_q  <= bus.mem_rdata;
                    state_q <= StWr;
                end
                StWr: begin
                    if (bus.mem_gnt) begin
                        src_q   <= src_q + WIDTH'(4);
                        dst_q   <= dst_q + WIDTH'(4);
                        rem_q   <= rem_q - CNT_W'(1);
                        state_q <= (rem_q != CNT_W'(1)) ? StRd : StFin;
                    end
                end
                StFin: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        done          = 1'b0;
        unique case (state_q)
            StRd, StWt: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = src_q;
            end
            StWr: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = dst_q;
                bus.mem_wdata = data_q;
                bus.mem_we    = bus.mem_gnt;
            end
            StFin: done = 1'b1;
            default: ;
        endcase
    end

    assign busy  = (state_q != StIdle);
    // Stall in the issue cycle too, so fetch never advances past the MEMC instruction.
    assign stall = busy | start;

endmodule

// File: tb/tb_memc_sequencer.sv
// Directed self-checking bench for memc_sequencer with a pattern-ROM memory model
// (read data = address ^ 32'h5A5A_0000).
module tb_memc_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] src_addr;
    logic [WIDTH-1:0] dst_addr;
    logic [CNT_W-1:0] count;
    logic             stall;
    logic             busy;
    logic             done;

    memc_sequencer_if #(.WIDTH(WIDTH)) mif ();

    memc_sequencer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .count    (count),
        .bus      (mif),
        .stall    (stall),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    logic [31:0] rd_q[$];
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    int          done_cnt;
    logic        rd_pend;

    logic [31:0] tr_addr [0:127];
    logic        tr_we   [0:127];
    int          req_cnt;
    int          viol_cnt;
    int          rb, wb, db;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory model and bus monitor; a granted read in WT is the same access, not a new one.
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (!rst) begin
            rd_pend <= 1'b0;
        end else if (mif.mem_req && mif.mem_gnt && !mif.mem_we && !rd_pend) begin
            rd_q.push_back(mif.mem_addr);
            mif.mem_rdata <= rd_val(mif.mem_addr);
            rd_pend       <= 1'b1;
        end else begin
            rd_pend <= 1'b0;
        end
        if (mif.mem_we) begin
            wr_a.push_back(mif.mem_addr);
            wr_d.push_back(mif.mem_wdata);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one copy; gmask bit i is the grant in cycle i+1 after start. lat = cycle done seen.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] c,
                            input logic [63:0] gmask, input int restart_at, output int lat);
        rb       = rd_q.size();
        wb       = wr_a.size();
        db       = done_cnt;
        req_cnt  = 0;
        viol_cnt = 0;
        lat      = -1;
        src_addr = s;
        dst_addr = d;
        count    = c;
        start    = 1'b1;
        mif.mem_gnt = 1'b0;
        for (int cyc = 1; cyc <= 100 && lat < 0; cyc++) begin
            tick();
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                src_addr = 32'h0000_5000;
                dst_addr = 32'h0000_6000;
                count    = 16'd9;
            end
            mif.mem_gnt = (cyc <= 64) ? gmask[cyc-1] : 1'b1;
            #1;
            tr_addr[cyc] = mif.mem_addr;
            tr_we[cyc]   = mif.mem_we;
            if (mif.mem_req) req_cnt++;
            if (mif.mem_we && !mif.mem_gnt) viol_cnt++;
            if (!mif.mem_req && (mif.mem_addr != '0 || mif.mem_wdata != '0)) viol_cnt++;
            if (done) lat = cyc;
        end
        start       = 1'b0;
        mif.mem_gnt = 1'b0;
        tick();
    endtask

    initial begin
        int lat;
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        start       = 1'b0;
        src_addr    = '0;
        dst_addr    = '0;
        count       = '0;
        mif.mem_gnt = 1'b0;
        tick();
        tick();
        check_val("rst_busy",  busy, 0);
        check_val("rst_done",  done, 0);
        check_val("rst_stall", stall, 0);
        check_val("rst_req",   mif.mem_req, 0);
        check_val("rst_we",    mif.mem_we, 0);
        check_val("rst_addr",  mif.mem_addr, 0);
        check_val("rst_wdata", mif.mem_wdata, 0);
        rst   = 1'b1;
        start = 1'b1;
        #1;
        check_val("idle_start_stall", stall, 1);
        check_val("idle_start_busy",  busy, 0);
        start = 1'b0;
        tick();

        // Basic three-word copy, always granted.
        run_copy(32'h100, 32'h200, 16'd3, '1, 0, lat);
        check_val("t1_latency", lat, 10);
        check_val("t1_nrd", rd_q.size() - rb, 3);
        check_val("t1_nwr", wr_a.size() - wb, 3);
        for (int i = 0; i < 3; i++) begin
            check_val("t1_rd_addr", rd_q[rb+i], 32'h100 + 32'(4*i));
            check_val("t1_wr_addr", wr_a[wb+i], 32'h200 + 32'(4*i));
            check_val("t1_wr_data", wr_d[wb+i], 32'h5A5A_0100 + 32'(4*i));
        end
        check_val("t1_viol", viol_cnt, 0);
        check_val("t1_ndone", done_cnt - db, 1);
        check_val("t1_done_after", done, 0);
        check_val("t1_busy_after", busy, 0);

        // Zero-length copy.
        run_copy(32'h40, 32'h80, 16'd0, '1, 0, lat);
        check_val("t2_latency", lat, 1);
        check_val("t2_req_cycles", req_cnt, 0);
        check_val("t2_nwr", wr_a.size() - wb, 0);
        check_val("t2_ndone", done_cnt - db, 1);

        // Grant withheld 4 cycles in RD, low in WT, withheld 3 cycles in WR of word 1.
        run_copy(32'h1000, 32'h2000, 16'd2, 64'hFFFF_FFFF_FFFF_FE10, 0, lat);
        check_val("t3_latency", lat, 14);
        check_val("t3_hold_rd2", tr_addr[2], 32'h1000);
        check_val("t3_hold_rd4", tr_addr[4], 32'h1000);
        check_val("t3_hold_wr8", tr_addr[8], 32'h2000);
        check_val("t3_we_ungnt", tr_we[8], 0);
        check_val("t3_we_gnt", tr_we[10], 1);
        check_val("t3_nrd", rd_q.size() - rb, 2);
        check_val("t3_nwr", wr_a.size() - wb, 2);
        check_val("t3_wr0_data", wr_d[wb], 32'h5A5A_1000);
        check_val("t3_wr1_addr", wr_a[wb+1], 32'h2004);
        check_val("t3_wr1_data", wr_d[wb+1], 32'h5A5A_1004);
        check_val("t3_viol", viol_cnt, 0);

        // Source address wraps through zero.
        run_copy(32'hFFFF_FFFC, 32'h0, 16'd2, '1, 0, lat);
        check_val("t4_latency", lat, 7);
        check_val("t4_rd0", rd_q[rb], 32'hFFFF_FFFC);
        check_val("t4_rd1_wrap", rd_q[rb+1], 32'h0);
        check_val("t4_wr0_addr", wr_a[wb], 32'h0);
        check_val("t4_wr1_addr", wr_a[wb+1], 32'h4);
        check_val("t4_wr0_data", wr_d[wb], 32'hA5A5_FFFC);
        check_val("t4_wr1_data", wr_d[wb+1], 32'h5A5A_0000);

        // Second start while busy is ignored.
        run_copy(32'h300, 32'h400, 16'd2, '1, 3, lat);
        check_val("t6_latency", lat, 7);
        check_val("t6_nrd", rd_q.size() - rb, 2);
        check_val("t6_rd1", rd_q[rb+1], 32'h304);
        check_val("t6_nwr", wr_a.size() - wb, 2);
        check_val("t6_wr1_addr", wr_a[wb+1], 32'h404);
        check_val("t6_wr1_data", wr_d[wb+1], 32'h5A5A_0304);
        check_val("t6_ndone", done_cnt - db, 1);

        // Reset during WR of word 2 of 4.
        wb          = wr_a.size();
        db          = done_cnt;
        src_addr    = 32'h800;
        dst_addr    = 32'h900;
        count       = 16'd4;
        start       = 1'b1;
        mif.mem_gnt = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        mif.mem_gnt = 1'b0;
        rst         = 1'b0;
        #1;
        check_val("t5_in_wr_addr", mif.mem_addr, 32'h904);
        check_val("t5_in_wr_req", mif.mem_req, 1);
        tick();
        check_val("t5_busy", busy, 0);
        check_val("t5_req", mif.mem_req, 0);
        check_val("t5_stall", stall, 0);
        rst         = 1'b1;
        mif.mem_gnt = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_val("t5_ndone", done_cnt - db, 0);
        check_val("t5_nwr", wr_a.size() - wb, 1);
        check_val("t5_wr0_addr", wr_a[wb], 32'h900);
        check_val("t5_busy_late", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/memc_sequencer.md
MEMC_SEQUENCER -- requirements
Module: memc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: data and address width.
REQ-002 Parameter CNT_W, default 16: word-count width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  controller multi_cy strobe; MEMC instruction in execute.
REQ-006 src_addr  input  WIDTH  source byte address, word aligned (rs1 value).
REQ-007 dst_addr  input  WIDTH  destination byte address, word aligned (rs2 value).
REQ-008 count  input  CNT_W  number of 32-bit words to copy.
REQ-009 mem_gnt  input  1  data-memory port granted to this block this cycle.
REQ-010 mem_rdata  input  WIDTH  read data; valid one cycle after a granted read.
REQ-011 mem_req  output  1  request for the data-memory port.
REQ-012 mem_addr  output  WIDTH  data-memory address.
REQ-013 mem_wdata  output  WIDTH  data-memory write data.
REQ-014 mem_we  output  1  data-memory write enable.
REQ-015 stall  output  1  holds PC and fetch while copy is in progress.
REQ-016 busy  output  1  sequencer not IDLE.
REQ-017 done  output  1  one-cycle pulse at copy completion.

Function
REQ-018 States SHALL be IDLE, RD, WT, WR, FIN; encoding implementer's choice.
REQ-019 In IDLE with start=1, SHALL latch src_addr, dst_addr, count into internal src_q, dst_q, rem_q and go to RD if count!=0, else FIN.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 RD: mem_req=1, mem_we=0, mem_addr=src_q; on mem_gnt=1 go to WT, else stay in RD.
REQ-022 WT: mem_req=1, mem_we=0; capture mem_rdata into data_q; go to WR unconditionally.
REQ-023 WR: mem_req=1, mem_addr=dst_q, mem_wdata=data_q, mem_we=mem_gnt; on mem_gnt=1 increment src_q and dst_q by 4, decrement rem_q, and go to RD if rem_q!=1, else FIN.
REQ-024 mem_we SHALL never be 1 without mem_gnt=1 in the same cycle.
REQ-025 FIN: done=1 for exactly one cycle, then IDLE; mem_req=0.
REQ-026 stall SHALL be 1 in IDLE when start=1 (combinational) and in RD, WT, WR, FIN; 0 otherwise.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 Address increments SHALL wrap modulo 2^WIDTH; no bounds error.
REQ-029 Copy order SHALL be ascending; overlapping regions are not corrected.
REQ-030 Ungranted throughput: 3 cycles per word; total latency start to done = 3*count+1 cycles.
REQ-031 mem_addr and mem_wdata SHALL be 0 whenever mem_req=0.
REQ-032 mem_gnt deasserted during WT SHALL not affect capture (read already issued).

Reset
REQ-033 rst=0 at a rising edge SHALL force IDLE; clear src_q, dst_q, rem_q, data_q to 0.
REQ-034 After reset all outputs SHALL be 0 (stall 0 unless start=1).
REQ-035 Reset mid-copy SHALL abandon the copy; no done pulse; no further writes.

Verification
REQ-036 src=0x100, dst=0x200, count=3, mem_gnt=1 -> reads 0x100/104/108, writes 0x200/204/208 with matching data; done at cycle 10 after start.
REQ-037 count=0 with start -> FIN next cycle, done pulse, no mem_req, no write.
REQ-038 count=2, mem_gnt held 0 for 4 cycles in RD and 3 in WR -> addresses held, mem_we=0 while ungranted; latency 7+7=14 cycles.
REQ-039 src=0xFFFFFFFC, dst=0x0, count=2 -> second read at 0x00000000 (wrap), writes 0x0 and 0x4.
REQ-040 rst=0 asserted in WR of word 2 of 4 -> IDLE next cycle, busy=0, no done, no writes to remaining words.
REQ-041 start pulsed again while busy -> ignored; latched parameters unchanged; single done.
